// File: rtl/display_pkg.sv
// Shared constants for the seven-segment scan display: digit count, blank code,
// decimal-point mask and the active-low hex-to-segment table.
package display_pkg;

  localparam int         NUM_DIGITS = 8;
  localparam logic [7:0] SEG_BLANK  = 8'hFF;
  localparam logic [7:0] DP_MASK    = 8'b0101_0000;

  // Active-low {g,f,e,d,c,b,a}, entry n at index n (F listed first).
  localparam logic [15:0][6:0] HEX_SEG = {
    7'b0001110, 7'b0000110, 7'b0100001, 7'b1000110,
    7'b0000011, 7'b0001000, 7'b0010000, 7'b0000000,
    7'b1111000, 7'b0000010, 7'b0010010, 7'b0011001,
    7'b0110000, 7'b0100100, 7'b1111001, 7'b1000000
  };

endpackage

// File: rtl/hex7seg.sv
// Combinational 4-bit to active-low 7-segment decoder, output {g,f,e,d,c,b,a}.
module hex7seg
  import display_pkg::*;
(
  input  logic [3:0] nib_i,
  output logic [6:0] seg_o
);

  assign seg_o = HEX_SEG[nib_i];

endmodule

// File: rtl/seg7_scan_display.sv
// 8-digit multiplexed active-low display of {opr1, opr2, result}, with a per-frame
// snapshot so a frame never mixes old and new values. an/seg lag idx by one cycle.
module seg7_scan_display
  import display_pkg::*;
#(
  parameter int DIGIT_TICKS = 100000,
  parameter int CNT_W       = 17
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [7:0]            opr1,
  input  logic [7:0]            opr2,
  input  logic [15:0]           result,
  input  logic                  blank_en,
  output logic [NUM_DIGITS-1:0] an,
  output logic [7:0]            seg,
  output logic                  frame_done
);

  logic [CNT_W-1:0]        cnt_q;
  logic [2:0]              idx_q;
  logic [4*NUM_DIGITS-1:0] snap_q;
  logic [NUM_DIGITS-1:0]   an_q, an_d;
  logic [7:0]              seg_q, seg_d;
  logic                    frame_done_q;

  logic       slot_end;
  logic [3:0] nib;
  logic [6:0] hex_seg;
  logic [3:1] rz;
  logic       blank;

  assign slot_end = (cnt_q == CNT_W'(DIGIT_TICKS - 1));
  assign nib      = snap_q[{idx_q, 2'b00} +: 4];

  hex7seg u_hex7seg (
    .nib_i (nib),
    .seg_o (hex_seg)
  );

  // A result digit is blanked only when it and every more significant result digit are zero.
  always_comb begin
    rz[1] = (snap_q[7:4]   == 4'h0);
    rz[2] = (snap_q[11:8]  == 4'h0);
    rz[3] = (snap_q[15:12] == 4'h0);
    blank = 1'b0;
    if (blank_en) begin
      case (idx_q)
        3'd1:    blank = &rz[3:1];
        3'd2:    blank = &rz[3:2];
        3'd3:    blank = rz[3];
        default: blank = 1'b0;
      endcase
    end
    an_d  = ~(NUM_DIGITS'(1) << idx_q);
    seg_d = {~DP_MASK[idx_q], hex_seg};
    if (blank) begin
      an_d  = '1;
      seg_d = SEG_BLANK;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q        <= '0;
      idx_q        <= '0;
      snap_q       <= '0;
      an_q         <= '1;
      seg_q        <= SEG_BLANK;
      frame_done_q <= 1'b0;
    end else begin
      an_q         <= an_d;
      seg_q        <= seg_d;
      frame_done_q <= 1'b0;
      if (slot_end) begin
        cnt_q <= '0;
        idx_q <= idx_q + 3'd1;
        if (idx_q == 3'd7) begin
          snap_q       <= {opr1, opr2, result};
          frame_done_q <= 1'b1;
        end
      end else begin
        cnt_q <= cnt_q + CNT_W'(1);
      end
    end
  end

  assign an         = an_q;
  assign seg        = seg_q;
  assign frame_done = frame_done_q;

endmodule

// File: tb/tb_seg7_scan_display.sv
// Randomized bench for seg7_scan_display against a frame/slot arithmetic model (DIGIT_TICKS=4).
module tb_seg7_scan_display;

  logic        clk;
  logic        rst;
  logic [7:0]  opr1;
  logic [7:0]  opr2;
  logic [15:0] result;
  logic        blank_en;
  logic [7:0]  an;
  logic [7:0]  seg;
  logic        frame_done;

  int n_chk;
  int n_fail;
  int e;                      // rising edges since reset release
  logic [31:0] snaps [256];   // snapshot displayed in frame f

  logic [6:0] seg_tab [16] = '{
    7'b1000000, 7'b1111001, 7'b0100100, 7'b0110000,
    7'b0011001, 7'b0010010, 7'b0000010, 7'b1111000,
    7'b0000000, 7'b0010000, 7'b0001000, 7'b0000011,
    7'b1000110, 7'b0100001, 7'b0000110, 7'b0001110
  };

  seg7_scan_display #(.DIGIT_TICKS(4), .CNT_W(3)) dut (
    .clk        (clk),
    .rst        (rst),
    .opr1       (opr1),
    .opr2       (opr2),
    .result     (result),
    .blank_en   (blank_en),
    .an         (an),
    .seg        (seg),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (edge %0d)", tag, got, exp, e);
    end
  endtask

  // One clock; outputs after edge e show slot (e-1)/4 of frame (e-1)/32.
  task automatic tick();
    int f, d;
    logic [31:0] s;
    logic [3:0] nib;
    logic b, bl;
    logic [7:0] ean, eseg;
    @(posedge clk);
    e++;
    b = blank_en;
    if (e % 32 == 0) snaps[(e / 32) % 256] = {opr1, opr2, result};
    #1;
    f = (e - 1) / 32;
    d = ((e - 1) / 4) % 8;
    s = snaps[f % 256];
    nib = 4'((s >> (4 * d)) & 32'hF);
    bl = b && (d >= 1) && (d <= 3) && (((s & 32'hFFFF) >> (4 * d)) == 0);
    if (bl) begin
      ean  = 8'hFF;
      eseg = 8'hFF;
    end else begin
      ean  = ~(8'(1) << d);
      eseg = {((d == 4) || (d == 6)) ? 1'b0 : 1'b1, seg_tab[nib]};
    end
    chk("an", 32'(an), 32'(ean));
    chk("seg", 32'(seg), 32'(eseg));
    chk("frame_done", 32'(frame_done), 32'(e % 32 == 0));
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic restart_model();
    e = 0;
    snaps[0] = '0;
  endtask

  task automatic check_reset_state(input string tag);
    chk({tag, "_an"}, 32'(an), 32'hFF);
    chk({tag, "_seg"}, 32'(seg), 32'hFF);
    chk({tag, "_fd"}, 32'(frame_done), 32'h0);
  endtask

  initial begin
    logic [15:0] sweep [4] = '{16'hFEDC, 16'hBA98, 16'h7654, 16'h3210};
    logic [15:0] r;
    n_chk = 0;
    n_fail = 0;
    e = 0;
    rst = 1'b1;
    opr1 = 8'h12;
    opr2 = 8'h34;
    result = 16'h5678;
    blank_en = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk);
      #1;
      check_reset_state("reset");
    end
    rst = 1'b0;
    restart_model();

    // Two full frames: zeros first, then 1,2,3,4,5,6,7,8.
    run(70);

    // Tearing: change result while slot 2 is current.
    for (int i = 0; i < 40 && ((e / 4) % 8) != 2; i++) tick();
    result = 16'h9ABC;
    run(70);

    // Leading-zero blanking.
    blank_en = 1'b1;
    result = 16'h0005;
    run(70);
    result = 16'h0000;
    run(70);
    result = 16'h0050;
    run(70);
    blank_en = 1'b0;

    // Hex table sweep; opr2 low nibble A exercises digit 4 with dp lit.
    for (int k = 0; k < 4; k++) begin
      result = sweep[k];
      opr1 = 8'hF0 ^ 8'(k * 17);
      opr2 = 8'hBA;
      run(66);
    end

    // Random inputs, frequently with leading zeros in result.
    for (int k = 0; k < 40; k++) begin
      r = 16'($urandom);
      r = r >> (4 * $urandom_range(0, 4));
      result = r;
      opr1 = 8'($urandom);
      opr2 = 8'($urandom);
      blank_en = 1'($urandom);
      run($urandom_range(1, 45));
    end

    // Asynchronous reset between edges while slot 5 is current.
    for (int i = 0; i < 40 && ((e / 4) % 8) != 5; i++) tick();
    #2;
    rst = 1'b1;
    #1;
    check_reset_state("async_rst");
    for (int i = 0; i < 2; i++) begin
      @(posedge clk);
      #1;
      check_reset_state("async_hold");
    end
    opr1 = 8'hA5;
    opr2 = 8'h3C;
    result = 16'h00F1;
    blank_en = 1'b1;
    rst = 1'b0;
    restart_model();
    run(70);
    for (int k = 0; k < 10; k++) begin
      result = 16'($urandom);
      opr1 = 8'($urandom);
      opr2 = 8'($urandom);
      blank_en = 1'($urandom);
      run($urandom_range(5, 40));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
